// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// State encodings are fixed so that waveforms and debug tooling stay stable.
package ifu_pkg;

  localparam int          IFU_XLEN     = 64;
  localparam int          IFU_INST_W   = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

  typedef logic [IFU_INST_W-1:0] inst_t;
  typedef logic [IFU_XLEN-1:0]   pc_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bus bundle: instruction memory port plus the idu hand-off.
// master = ifu view, slave = memory/idu view.
interface ifu_if #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
);
  logic              imem_req_o;
  logic [XLEN-1:0]   imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [INST_W-1:0] imem_rdata_i;
  logic              imem_err_i;
  logic [INST_W-1:0] inst_o;
  logic [XLEN-1:0]   pc_o;
  logic              fault_o;
  logic              valid_o;
  logic              ready_i;

  modport master (
    output imem_req_o, imem_addr_o, inst_o, pc_o, fault_o, valid_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i, ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, inst_o, pc_o, fault_o, valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, imem_err_i, ready_i
  );
endinterface

// File: rtl/ifu_pc_gen.sv
// Next-PC selection (reset > redirect > sequential advance > hold) and
// misalignment flag of the selected PC.
module ifu_pc_gen
  import ifu_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            advance_i,
  input  logic [XLEN-1:0] pc_q_i,
  output logic [XLEN-1:0] pc_d_o,
  output logic            misalign_o
);

  always_comb begin
    pc_d_o = pc_q_i;
    if (rst_i)           pc_d_o = RESET_PC;
    else if (redirect_i) pc_d_o = redirect_pc_i;
    else if (advance_i)  pc_d_o = pc_q_i + XLEN'(4);  // wraps modulo 2^XLEN
  end

  assign misalign_o = |pc_d_o[1:0];

endmodule

// File: rtl/ifu.sv
// Instruction fetch stage: single-outstanding fetch FSM, stale-response drop
// flag and registered hold stage presented to idu.
module ifu
  import ifu_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter int              INST_W   = IFU_INST_W,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  ifu_if.master           bus
);

  localparam logic [INST_W-1:0] NOP = INST_W'(IFU_NOP);

  ifu_state_e        state_q, state_d;
  logic              drop_q, drop_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [XLEN-1:0]   hpc_q, hpc_d;
  logic              fault_q, fault_d;
  logic              advance;
  logic              pc_misal;

  ifu_pc_gen #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_gen (
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .advance_i     (advance),
    .pc_q_i        (pc_q),
    .pc_d_o        (pc_d),
    .misalign_o    (pc_misal)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    hpc_d   = hpc_q;
    fault_d = fault_q;
    advance = 1'b0;
    case (state_q)
      S_REQ: begin
        // a request accepted together with a redirect already targets the old PC
        if (bus.imem_gnt_i) begin
          state_d = S_WAIT;
          drop_d  = redirect_i;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid_i) begin
          if (drop_q || redirect_i) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = S_HOLD;
            inst_d  = bus.imem_err_i ? NOP : bus.imem_rdata_i;
            fault_d = bus.imem_err_i;
            hpc_d   = pc_q;
          end
        end else if (redirect_i) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          state_d = S_REQ;
        end else if (bus.ready_i) begin
          state_d = S_REQ;
          advance = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase
    // a misaligned PC never reaches memory; it is presented as a fault instead
    if (state_d == S_REQ && pc_misal) begin
      state_d = S_HOLD;
      inst_d  = NOP;
      fault_d = 1'b1;
      hpc_d   = pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_REQ;
      drop_q  <= 1'b0;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      hpc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      hpc_q   <= hpc_d;
      fault_q <= fault_d;
    end
  end

  assign bus.imem_req_o  = (state_q == S_REQ) && !rst_i;
  assign bus.imem_addr_o = pc_q;
  assign bus.inst_o      = inst_q;
  assign bus.pc_o        = hpc_q;
  assign bus.fault_o     = fault_q;
  assign bus.valid_o     = (state_q == S_HOLD) && !redirect_i && !rst_i;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: inputs change 1ns after the rising edge, outputs
// are checked 1ns later, well away from the next edge.
module tb_ifu;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [63:0] redirect_pc;
  int          cmp_cnt = 0;
  int          err_cnt = 0;

  ifu_if #(.XLEN(64), .INST_W(32)) bus ();

  ifu dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect = 1'b0; redirect_pc = '0;
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0; bus.imem_err_i = 1'b0; bus.ready_i = 1'b0;
  endtask

  // Grant the pending request, return the word one cycle later; ends in S_HOLD.
  task automatic serve(input logic [31:0] data, input logic err);
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = data; bus.imem_err_i = err;
    tick();
    bus.imem_rvalid_i = 1'b0; bus.imem_err_i = 1'b0; bus.imem_rdata_i = '0;
  endtask

  task automatic accept();
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    #1;
    cmp_cnt++; if (bus.imem_req_o !== 1'b0) begin err_cnt++; $display("FAIL rst_req got %b want 0", bus.imem_req_o); end
    cmp_cnt++; if (bus.valid_o !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got %b want 0", bus.valid_o); end
    cmp_cnt++; if (bus.inst_o !== 32'h0) begin err_cnt++; $display("FAIL rst_inst got %h want 0", bus.inst_o); end
    cmp_cnt++; if (bus.pc_o !== 64'h0) begin err_cnt++; $display("FAIL rst_pc got %h want 0", bus.pc_o); end
    cmp_cnt++; if (bus.fault_o !== 1'b0) begin err_cnt++; $display("FAIL rst_fault got %b want 0", bus.fault_o); end
    rst = 1'b0;
    #1;
    cmp_cnt++; if (bus.imem_req_o !== 1'b1) begin err_cnt++; $display("FAIL first_req got %b want 1", bus.imem_req_o); end
    cmp_cnt++; if (bus.imem_addr_o !== 64'h8000_0000) begin err_cnt++; $display("FAIL first_addr got %h want 80000000", bus.imem_addr_o); end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc;
    logic [31:0] data;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 64'h8000_0000 + 64'(4 * i);
      data   = 32'h0010_0093 + 32'(i);
      cmp_cnt++; if (bus.imem_addr_o !== exp_pc) begin err_cnt++; $display("FAIL seq_addr%0d got %h want %h", i, bus.imem_addr_o, exp_pc); end
      bus.imem_gnt_i = 1'b1;
      tick();
      bus.imem_gnt_i = 1'b0;
      #1;
      cmp_cnt++; if (bus.imem_req_o !== 1'b0) begin err_cnt++; $display("FAIL seq_wait_req%0d got %b want 0", i, bus.imem_req_o); end
      bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = data;
      tick();
      bus.imem_rvalid_i = 1'b0;
      bus.ready_i = 1'b1;
      #1;
      cmp_cnt++; if (bus.valid_o !== 1'b1) begin err_cnt++; $display("FAIL seq_valid%0d got %b want 1", i, bus.valid_o); end
      cmp_cnt++; if (bus.pc_o !== exp_pc) begin err_cnt++; $display("FAIL seq_pc%0d got %h want %h", i, bus.pc_o, exp_pc); end
      cmp_cnt++; if (bus.inst_o !== data) begin err_cnt++; $display("FAIL seq_inst%0d got %h want %h", i, bus.inst_o, data); end
      tick();
      bus.ready_i = 1'b0;
    end
  endtask

  task automatic test_stall();
    serve(32'h00A0_0093, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp_cnt++; if (bus.valid_o !== 1'b1) begin err_cnt++; $display("FAIL stall_valid%0d got %b want 1", i, bus.valid_o); end
      cmp_cnt++; if (bus.inst_o !== 32'h00A0_0093) begin err_cnt++; $display("FAIL stall_inst%0d got %h want 00a00093", i, bus.inst_o); end
      cmp_cnt++; if (bus.pc_o !== 64'h8000_000C) begin err_cnt++; $display("FAIL stall_pc%0d got %h want 8000000c", i, bus.pc_o); end
      cmp_cnt++; if (bus.imem_req_o !== 1'b0) begin err_cnt++; $display("FAIL stall_req%0d got %b want 0", i, bus.imem_req_o); end
      tick();
    end
    accept();
  endtask

  task automatic test_bus_error();
    #1;
    cmp_cnt++; if (bus.imem_addr_o !== 64'h8000_0010) begin err_cnt++; $display("FAIL err_addr got %h want 80000010", bus.imem_addr_o); end
    serve(32'h1234_5678, 1'b1);
    #1;
    cmp_cnt++; if (bus.fault_o !== 1'b1) begin err_cnt++; $display("FAIL err_fault got %b want 1", bus.fault_o); end
    cmp_cnt++; if (bus.inst_o !== 32'h0000_0013) begin err_cnt++; $display("FAIL err_inst got %h want 00000013", bus.inst_o); end
    cmp_cnt++; if (bus.pc_o !== 64'h8000_0010) begin err_cnt++; $display("FAIL err_pc got %h want 80000010", bus.pc_o); end
    accept();
  endtask

  task automatic test_redirect_wait();
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    redirect = 1'b0;
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    cmp_cnt++; if (bus.valid_o !== 1'b0) begin err_cnt++; $display("FAIL rdw_valid got %b want 0", bus.valid_o); end
    cmp_cnt++; if (bus.imem_req_o !== 1'b1) begin err_cnt++; $display("FAIL rdw_req got %b want 1", bus.imem_req_o); end
    cmp_cnt++; if (bus.imem_addr_o !== 64'h8000_0100) begin err_cnt++; $display("FAIL rdw_addr got %h want 80000100", bus.imem_addr_o); end
    serve(32'h1111_1111, 1'b0);
    #1;
    cmp_cnt++; if (bus.pc_o !== 64'h8000_0100) begin err_cnt++; $display("FAIL rdw_pc got %h want 80000100", bus.pc_o); end
    cmp_cnt++; if (bus.inst_o !== 32'h1111_1111) begin err_cnt++; $display("FAIL rdw_inst got %h want 11111111", bus.inst_o); end
  endtask

  // Starts in S_HOLD from the previous test.
  task automatic test_misaligned();
    redirect = 1'b1; redirect_pc = 64'h8000_0102;
    #1;
    cmp_cnt++; if (bus.valid_o !== 1'b0) begin err_cnt++; $display("FAIL mis_redir_valid got %b want 0", bus.valid_o); end
    tick();
    redirect = 1'b0;
    #1;
    cmp_cnt++; if (bus.imem_req_o !== 1'b0) begin err_cnt++; $display("FAIL mis_req got %b want 0", bus.imem_req_o); end
    cmp_cnt++; if (bus.valid_o !== 1'b1) begin err_cnt++; $display("FAIL mis_valid got %b want 1", bus.valid_o); end
    cmp_cnt++; if (bus.fault_o !== 1'b1) begin err_cnt++; $display("FAIL mis_fault got %b want 1", bus.fault_o); end
    cmp_cnt++; if (bus.inst_o !== 32'h0000_0013) begin err_cnt++; $display("FAIL mis_inst got %h want 00000013", bus.inst_o); end
    cmp_cnt++; if (bus.pc_o !== 64'h8000_0102) begin err_cnt++; $display("FAIL mis_pc got %h want 80000102", bus.pc_o); end
    accept();
    #1;
    cmp_cnt++; if (bus.pc_o !== 64'h8000_0106) begin err_cnt++; $display("FAIL mis_adv_pc got %h want 80000106", bus.pc_o); end
    cmp_cnt++; if (bus.imem_req_o !== 1'b0) begin err_cnt++; $display("FAIL mis_adv_req got %b want 0", bus.imem_req_o); end
    redirect = 1'b1; redirect_pc = 64'h8000_0200;
    tick();
    redirect = 1'b0;
    #1;
    cmp_cnt++; if (bus.imem_addr_o !== 64'h8000_0200 || bus.imem_req_o !== 1'b1) begin err_cnt++; $display("FAIL mis_exit got req=%b addr=%h want req=1 addr=80000200", bus.imem_req_o, bus.imem_addr_o); end
  endtask

  task automatic test_redirect_gnt();
    bus.imem_gnt_i = 1'b1; redirect = 1'b1; redirect_pc = 64'h8000_0300;
    tick();
    bus.imem_gnt_i = 1'b0; redirect = 1'b0;
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hBAD0_BAD0;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    cmp_cnt++; if (bus.valid_o !== 1'b0) begin err_cnt++; $display("FAIL rgn_valid got %b want 0", bus.valid_o); end
    cmp_cnt++; if (bus.imem_addr_o !== 64'h8000_0300 || bus.imem_req_o !== 1'b1) begin err_cnt++; $display("FAIL rgn_req got req=%b addr=%h want req=1 addr=80000300", bus.imem_req_o, bus.imem_addr_o); end
    serve(32'h2222_2222, 1'b0);
    #1;
    cmp_cnt++; if (bus.inst_o !== 32'h2222_2222 || bus.pc_o !== 64'h8000_0300) begin err_cnt++; $display("FAIL rgn_word got inst=%h pc=%h want inst=22222222 pc=80000300", bus.inst_o, bus.pc_o); end
    accept();
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect = 1'b0;
    serve(32'h3333_3333, 1'b0);
    #1;
    cmp_cnt++; if (bus.pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin err_cnt++; $display("FAIL wrap_pc got %h want fffffffffffffffc", bus.pc_o); end
    accept();
    #1;
    cmp_cnt++; if (bus.imem_addr_o !== 64'h0 || bus.imem_req_o !== 1'b1) begin err_cnt++; $display("FAIL wrap_addr got req=%b addr=%h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
  endtask

  // Reset lands while a stale response is pending; the first post-reset word must survive.
  task automatic test_reset_mid();
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h8000_0400;
    tick();
    redirect = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    cmp_cnt++; if (bus.valid_o !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid got %b want 0", bus.valid_o); end
    cmp_cnt++; if (bus.imem_addr_o !== 64'h8000_0000 || bus.imem_req_o !== 1'b1) begin err_cnt++; $display("FAIL rmid_req got req=%b addr=%h want req=1 addr=80000000", bus.imem_req_o, bus.imem_addr_o); end
    serve(32'h4444_4444, 1'b0);
    #1;
    cmp_cnt++; if (bus.valid_o !== 1'b1 || bus.inst_o !== 32'h4444_4444 || bus.pc_o !== 64'h8000_0000) begin err_cnt++; $display("FAIL rmid_word got v=%b inst=%h pc=%h want v=1 inst=44444444 pc=80000000", bus.valid_o, bus.inst_o, bus.pc_o); end
    accept();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_bus_error();
    test_redirect_wait();
    test_misaligned();
    test_redirect_gnt();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
